// File: rtl/seq_div_by2digit_ctrl_pkg.sv
// Shared definitions for the sequential by-2-bit-divisor divider: FSM encodings
// and the default dividend width.
package seq_div_by2digit_ctrl_pkg;
  localparam logic [1:0] S0     = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_END  = 2'd2;

  localparam int DEF_N = 8;
endpackage

// File: rtl/seq_div_by2digit_ctrl_n3by2_divider.sv
// One restoring-division step: a 3-bit partial dividend over a 2-bit divisor.
// The caller keeps a < 2*b, so the quotient is a single bit and r < b.
module seq_div_by2digit_ctrl_n3by2_divider (
  input  logic [2:0] a,
  input  logic [1:0] b,
  output logic       q,
  output logic [1:0] r
);
  logic [2:0] b_ext;
  logic [2:0] diff;

  assign b_ext = {1'b0, b};
  assign diff  = a - b_ext;
  assign q     = (a >= b_ext);

  // When q is 1 the difference is below b, so its MSB is always 0.
  always_comb begin
    r = a[1:0];
    if (q) r = {diff[1] & ~diff[2], diff[0]};
  end
endmodule

// File: rtl/seq_div_by2digit_ctrl.sv
// Sequential N-bit by 2-bit divider: one quotient bit per clock through a shared
// 3-by-2 step, behind a 4-phase soc/eoc handshake.
module seq_div_by2digit_ctrl
  import seq_div_by2digit_ctrl_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         soc,
  input  logic [N-1:0] x,
  input  logic [1:0]   y,
  output logic         eoc,
  output logic [N-1:0] q,
  output logic [1:0]   r,
  output logic         no_div
);
  logic [1:0]       star;
  logic [CNT_W-1:0] count;
  logic [N-1:0]     xr;
  logic [1:0]       yr;
  logic [1:0]       rem;
  logic [N-1:0]     qr;
  logic             div0;

  logic             step_q;
  logic [1:0]       step_r;
  logic [N-1:0]     q_next;

  seq_div_by2digit_ctrl_n3by2_divider u_step (
    .a (({rem, xr[N-1]})),
    .b (yr),
    .q (step_q),
    .r (step_r)
  );

  assign q_next = {qr[N-2:0], step_q};

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      star   <= S0;
      count  <= '0;
      xr     <= '0;
      yr     <= '0;
      rem    <= '0;
      qr     <= '0;
      div0   <= 1'b0;
      eoc    <= 1'b1;
      q      <= '0;
      r      <= '0;
      no_div <= 1'b0;
    end else begin
      case (star)
        S0: begin
          if (soc) begin
            xr    <= x;
            yr    <= y;
            rem   <= '0;
            qr    <= '0;
            count <= CNT_W'(N);
            eoc   <= 1'b0;
            div0  <= (y == 2'd0);
            star  <= (y == 2'd0) ? S_END : S_CALC;
          end
        end
        S_CALC: begin
          qr    <= q_next;
          rem   <= step_r;
          xr    <= xr << 1;
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            // Retire straight from the last step when soc has already dropped.
            if (!soc) begin
              q      <= q_next;
              r      <= step_r;
              no_div <= 1'b0;
              eoc    <= 1'b1;
              star   <= S0;
            end else begin
              star <= S_END;
            end
          end
        end
        S_END: begin
          if (!soc) begin
            q      <= qr;
            r      <= rem;
            no_div <= div0;
            eoc    <= 1'b1;
            star   <= S0;
          end
        end
        default: star <= S0;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_div_by2digit_ctrl.sv
// Self-checking bench: directed table, handshake corner cases, mid-op reset,
// random ops against an arithmetic model, and an N=4 instance.
module tb_seq_div_by2digit_ctrl;
  localparam int N = 8;

  logic         clock = 1'b0;
  logic         reset_;
  logic         soc;
  logic [N-1:0] x;
  logic [1:0]   y;
  logic         eoc;
  logic [N-1:0] q;
  logic [1:0]   r;
  logic         no_div;

  logic         soc4;
  logic [3:0]   x4;
  logic [1:0]   y4;
  logic         eoc4;
  logic [3:0]   q4;
  logic [1:0]   r4;
  logic         no_div4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  seq_div_by2digit_ctrl #(.N(N)) dut (
    .clock(clock), .reset_(reset_), .soc(soc), .x(x), .y(y),
    .eoc(eoc), .q(q), .r(r), .no_div(no_div)
  );

  seq_div_by2digit_ctrl #(.N(4)) dut4 (
    .clock(clock), .reset_(reset_), .soc(soc4), .x(x4), .y(y4),
    .eoc(eoc4), .q(q4), .r(r4), .no_div(no_div4)
  );

  typedef struct {
    int x;
    int y;
    int eq;
    int er;
    int end_nd;
    int elat;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference latency: a div-by-zero needs accept + one finishing edge, a real
  // divide needs accept + N steps; either way completion waits for soc to fall.
  function automatic int model_lat(input int yv, input int hold);
    int base;
    base = (yv == 0) ? 2 : N + 1;
    return (hold + 1 > base) ? hold + 1 : base;
  endfunction

  // Raise soc for 'hold' edges, then drop it; count edges until eoc returns.
  task automatic do_op(input int xv, input int yv, input int hold,
                       output int lat, output int changed);
    logic [N-1:0] qb;
    logic [1:0]   rb;
    logic         nb;
    bit           done;
    @(negedge clock);
    qb = q; rb = r; nb = no_div;
    x = N'(xv); y = 2'(yv); soc = 1'b1;
    lat = 0; changed = 0; done = 1'b0;
    while (!done && lat < 300) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (lat >= hold) soc = 1'b0;
      if (eoc) done = 1'b1;
      else if (q !== qb || r !== rb || no_div !== nb) changed = 1;
    end
    if (!done) check("eoc_timeout", 0, 1);
  endtask

  vec_t tbl[6];
  int   lat, chg;

  initial begin
    tbl[0] = '{200, 3, 66, 2, 0, 9};
    tbl[1] = '{255, 1, 255, 0, 0, 9};
    tbl[2] = '{5, 3, 1, 2, 0, 9};
    tbl[3] = '{0, 2, 0, 0, 0, 9};
    tbl[4] = '{7, 0, 0, 0, 1, 2};
    tbl[5] = '{9, 2, 4, 1, 0, 9};

    reset_ = 1'b0; soc = 1'b0; x = '0; y = '0;
    soc4 = 1'b0; x4 = '0; y4 = '0;
    repeat (2) @(negedge clock);
    check("rst_eoc", int'(eoc), 1);
    check("rst_q", int'(q), 0);
    check("rst_r", int'(r), 0);
    check("rst_no_div", int'(no_div), 0);
    reset_ = 1'b1;
    @(negedge clock);

    foreach (tbl[i]) begin
      do_op(tbl[i].x, tbl[i].y, 1, lat, chg);
      check($sformatf("tbl%0d_q", i), int'(q), tbl[i].eq);
      check($sformatf("tbl%0d_r", i), int'(r), tbl[i].er);
      check($sformatf("tbl%0d_no_div", i), int'(no_div), tbl[i].end_nd);
      check($sformatf("tbl%0d_lat", i), lat, tbl[i].elat);
      check($sformatf("tbl%0d_stable", i), chg, 0);
    end

    // soc held long: completion only after soc falls, old result held meanwhile
    do_op(50, 3, 20, lat, chg);
    check("hold_lat", lat, 21);
    check("hold_stable", chg, 0);
    check("hold_q", int'(q), 16);
    check("hold_r", int'(r), 2);

    // soc dropping exactly before the last step still finishes at N+1
    do_op(77, 2, N, lat, chg);
    check("late_drop_lat", lat, N + 1);
    check("late_drop_q", int'(q), 38);

    // reset in the middle of the computation
    @(negedge clock);
    x = 8'd200; y = 2'd3; soc = 1'b1;
    @(posedge clock);
    @(negedge clock);
    soc = 1'b0;
    repeat (4) @(negedge clock);
    check("mid_busy", int'(eoc), 0);
    reset_ = 1'b0;
    #1;
    check("mid_rst_eoc", int'(eoc), 1);
    check("mid_rst_q", int'(q), 0);
    check("mid_rst_r", int'(r), 0);
    @(negedge clock);
    reset_ = 1'b1;
    do_op(100, 3, 1, lat, chg);
    check("post_rst_q", int'(q), 33);
    check("post_rst_r", int'(r), 1);
    check("post_rst_lat", lat, 9);

    // random back-to-back ops against x/y, x%y
    for (int k = 0; k < 500; k++) begin
      int xv, yv, hv;
      xv = int'($urandom_range(255, 0));
      yv = int'($urandom_range(3, 1));
      hv = int'($urandom_range(12, 1));
      do_op(xv, yv, hv, lat, chg);
      check("rnd_q", int'(q), xv / yv);
      check("rnd_r", int'(r), xv % yv);
      check("rnd_no_div", int'(no_div), 0);
      check("rnd_lat", lat, model_lat(yv, hv));
      check("rnd_stable", chg, 0);
    end

    // narrow instance, N=4
    begin
      int l4;
      bit d4;
      @(negedge clock);
      x4 = 4'd15; y4 = 2'd2; soc4 = 1'b1;
      @(posedge clock);
      @(negedge clock);
      soc4 = 1'b0;
      l4 = 1; d4 = 1'b0;
      while (!d4 && l4 < 50) begin
        @(posedge clock);
        l4++;
        @(negedge clock);
        if (eoc4) d4 = 1'b1;
      end
      check("n4_done", int'(d4), 1);
      check("n4_lat", l4, 5);
      check("n4_q", int'(q4), 7);
      check("n4_r", int'(r4), 1);
      check("n4_no_div", int'(no_div4), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
